// File: rtl/reg_scan_pkg.sv
// Shared types and default widths for the debug register-scan controller.
// Define REG_SCAN_PARITY_EN to append an even-parity bit to every serial frame.
package reg_scan_pkg;

    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;
    localparam int DEF_DW    = 8;

`ifdef REG_SCAN_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_WRITE    = 2'd1,
        OP_READ_ONE = 2'd2,
        OP_READ_ALL = 2'd3
    } scan_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WRITE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/reg_scan_piso.sv
// Parallel-load, MSB-first serialiser with frame bit counter and last-bit flag.
// With REG_SCAN_PARITY_EN the frame carries one trailing even-parity bit.
module reg_scan_piso
    import reg_scan_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          ser_last
);

    localparam int FW = DW + PAR_BITS;
    localparam int CW = (FW > 1) ? $clog2(FW) : 1;

    logic [FW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [FW-1:0] frame;

`ifdef REG_SCAN_PARITY_EN
    assign frame = {load_data, ^load_data};
`else
    assign frame = load_data;
`endif

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            shreg_d  = frame;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(FW - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign ser_out   = active_q & shreg_q[FW-1];
    assign ser_valid = active_q;
    assign ser_last  = active_q && (cnt_q == CW'(FW - 1));

endmodule

// File: rtl/reg_scan_ctrl.sv
// Debug-side initiator for the CPU register file: arbitrates for the ports, then writes
// one register or serialises one/all registers. REG_SCAN_PARITY_EN adds a parity bit per frame.
module reg_scan_ctrl
    import reg_scan_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          dbg_req,
    input  logic          dbg_gnt,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic [AW-1:0] rf_wr_addr,
    output logic          rf_wr_en,
    output logic [DW-1:0] rf_wr_data,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          ser_last,
    output logic          done
);

    scan_state_e   state_q, state_d;
    scan_op_e      op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [DW-1:0] data_q, data_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          dbg_req_q, dbg_req_d;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;
    scan_op_e      op_in;
    logic          frame_last;

    assign op_in = scan_op_e'(cmd_op);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cur_d   = cur_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = op_in;
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    cur_d   = (op_in == OP_READ_ALL) ? '0 : cmd_addr;
                    state_d = (op_in == OP_NOP) ? ST_DONE : ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                if (dbg_gnt) begin
                    state_d = (op_q == OP_WRITE) ? ST_WRITE : ST_LOAD;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                // READ_ALL stops at the top register rather than wrapping to 0.
                if (frame_last) begin
                    if (op_q == OP_READ_ALL && cur_q != AW'(NREGS - 1)) begin
                        cur_d   = cur_q + AW'(1);
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        dbg_req_d   = (state_d == ST_WAIT_GNT) || (state_d == ST_WRITE) ||
                      (state_d == ST_LOAD)     || (state_d == ST_SHIFT);
        wr_en_d     = (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            cur_q       <= '0;
            data_q      <= '0;
            cmd_ready_q <= 1'b0;
            dbg_req_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cur_q       <= cur_d;
            data_q      <= data_d;
            cmd_ready_q <= cmd_ready_d;
            dbg_req_q   <= dbg_req_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
        end
    end

    reg_scan_piso #(.DW(DW)) u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state_q == ST_LOAD),
        .load_data (rf_rd_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (frame_last)
    );

    assign ser_last   = frame_last;
    assign cmd_ready  = cmd_ready_q;
    assign dbg_req    = dbg_req_q;
    assign rf_rd_addr = cur_q;
    assign rf_wr_addr = addr_q;
    assign rf_wr_data = data_q;
    assign rf_wr_en   = wr_en_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_scan_ctrl.sv
// Scoreboard bench for reg_scan_ctrl: driver pushes expected writes, serial bits and done
// cycles derived from a register-array model; a negedge monitor pops and compares.
module tb_reg_scan_ctrl;

    localparam int NR  = 8;
    localparam int DWB = 8;
`ifdef REG_SCAN_PARITY_EN
    localparam int FWB = DWB + 1;
`else
    localparam int FWB = DWB;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       dbg_req;
    logic       dbg_gnt = 1'b1;
    logic [2:0] rf_rd_addr;
    logic [7:0] rf_rd_data;
    logic [2:0] rf_wr_addr;
    logic       rf_wr_en;
    logic [7:0] rf_wr_data;
    logic       ser_out, ser_valid, ser_last, done;

    typedef struct { logic val; logic last; } bit_t;
    typedef struct { logic [2:0] a; logic [7:0] d; int cyc; } wr_t;

    bit_t       bit_q[$];
    wr_t        wr_q[$];
    int         done_q[$];
    logic [7:0] mdl [NR];
    logic [7:0] rf_env [NR];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    reg_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_addr(rf_wr_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file the DUT talks to: combinational read, written only by the DUT.
    assign rf_rd_data = rf_env[rf_rd_addr];
    always @(posedge clk) if (rf_wr_en) rf_env[rf_wr_addr] <= rf_wr_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_frame(input logic [7:0] v);
        for (int i = DWB - 1; i >= 0; i--) bit_q.push_back('{v[i], (FWB == DWB) && (i == 0)});
`ifdef REG_SCAN_PARITY_EN
        bit_q.push_back('{^v, 1'b1});
`endif
    endtask

    task automatic flush();
        bit_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    // Issue one command; timed=1 means dbg_gnt is held high so exact latencies are expected.
    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                         input bit timed);
        int n;
        int g;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        g = 0;
        while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
        if (!cmd_ready) begin
            fail("accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        n = cyc;
        case (op)
            2'd0: done_q.push_back(timed ? n + 1 : -1);
            2'd1: begin
                wr_q.push_back('{a, d, timed ? n + 2 : -1});
                mdl[a] = d;
                done_q.push_back(timed ? n + 3 : -1);
            end
            2'd2: begin
                push_frame(mdl[a]);
                done_q.push_back(timed ? n + 3 + FWB : -1);
            end
            default: begin
                for (int i = 0; i < NR; i++) push_frame(mdl[i]);
                done_q.push_back(timed ? n + 2 + NR * (1 + FWB) : -1);
            end
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 3'($urandom); cmd_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((bit_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0 || !cmd_ready)
               && g < 2000) begin
            @(negedge clk); g++;
        end
        if (g >= 2000) begin
            fail("idle_timeout");
            flush();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_dbg_req"}, dbg_req, 0);
        chk({tag, "_rf_wr_en"}, rf_wr_en, 0);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_ser_out"}, ser_out, 0);
        chk({tag, "_ser_last"}, ser_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called just after a negedge: reset lands mid-cycle, well away from any clock edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        flush();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready_before_clk", cmd_ready, 0);
        @(negedge clk);
        chk("abort_ready_after_clk", cmd_ready, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    initial begin
        bit_t e;
        wr_t  w;
        int   c;
        forever begin
            @(negedge clk);
            if (ser_valid) begin
                if (bit_q.size() == 0) fail("ser_valid_unexpected");
                else begin
                    e = bit_q.pop_front();
                    chk("ser_out", ser_out, e.val);
                    chk("ser_last", ser_last, e.last);
                end
            end
            if (rf_wr_en) begin
                if (wr_q.size() == 0) fail("rf_wr_en_unexpected");
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", rf_wr_addr, w.a);
                    chk("wr_data", rf_wr_data, w.d);
                    if (w.cyc >= 0) chk("wr_cycle", cyc, w.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) fail("done_unexpected");
                else begin
                    c = done_q.pop_front();
                    if (c >= 0) chk("done_cycle", cyc, c);
                    chk("done_dbg_req", dbg_req, 0);
                    chk("done_bits_left", bit_q.size(), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] saved;
        for (int i = 0; i < NR; i++) mdl[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        chk("reset_rd_addr", rf_rd_addr, 0);
        chk("reset_wr_addr", rf_wr_addr, 0);
        chk("reset_wr_data", rf_wr_data, 0);
        rst_n = 1'b1;
        chk("ready_before_first_clk", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_first_clk", cmd_ready, 1);

        issue(2'd1, 3'd5, 8'hA5, 1'b1);
        wait_idle();
        for (int i = 0; i < NR; i++) issue(2'd1, 3'(i), 8'(8'h10 + i), 1'b1);
        issue(2'd1, 3'd3, 8'hC3, 1'b1);
        issue(2'd2, 3'd3, 8'h00, 1'b1);
        issue(2'd1, 3'd3, 8'h13, 1'b1);
        issue(2'd3, 3'd6, 8'h00, 1'b1);
        issue(2'd0, 3'd0, 8'h00, 1'b1);
        wait_idle();

        dbg_gnt = 1'b0;
        issue(2'd2, 3'd6, 8'h00, 1'b0);
        repeat (20) begin
            @(negedge clk);
            chk("hold_dbg_req", dbg_req, 1);
            chk("hold_wr_en", rf_wr_en, 0);
            chk("hold_ser_valid", ser_valid, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        dbg_gnt = 1'b1;
        wait_idle();

        issue(2'd1, 3'd1, 8'h07, 1'b1);
        issue(2'd2, 3'd1, 8'h00, 1'b1);
        issue(2'd1, 3'd2, 8'h03, 1'b1);
        issue(2'd2, 3'd2, 8'h00, 1'b1);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom), 8'($urandom), 1'b1);
        end
        wait_idle();

        saved = mdl[2];
        dbg_gnt = 1'b0;
        issue(2'd1, 3'd2, ~saved, 1'b0);
        repeat (3) @(negedge clk);
        mid_reset();
        mdl[2] = saved;
        dbg_gnt = 1'b1;
        issue(2'd2, 3'd2, 8'h00, 1'b1);
        wait_idle();

        issue(2'd3, 3'd0, 8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("abort_in_shift", ser_valid, 1);
        mid_reset();
        issue(2'd2, 3'd4, 8'h00, 1'b1);
        issue(2'd3, 3'd0, 8'h00, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
